// File: rtl/game_control.sv
// Frame sequencer for the flappy-bird datapath: erase, move, collide, redraw.
// Owns flap requests, score, game-over and the draw watchdog.
module game_control #(
    parameter logic [15:0] DRAW_TIMEOUT = 16'd20000,
    parameter logic [7:0]  SCORE_MAX    = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       frame_tick,
    input  logic       finished_draw,
    input  logic       collision,
    input  logic       wall_wrap,
    output logic [3:0] cur_state,
    output logic       start_draw,
    output logic       plot,
    output logic       erase,
    output logic       update_pos,
    output logic       flap,
    output logic       game_reset,
    output logic [7:0] score,
    output logic       game_over,
    output logic       draw_timeout,
    output logic       frame_overrun
);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_E_BIRD, S_E_TOP, S_E_BOT, S_UPDATE,
        S_CHECK, S_D_BIRD, S_D_TOP, S_D_BOT, S_OVER
    } state_e;

    function automatic logic is_draw(state_e s);
        case (s)
            S_E_BIRD, S_E_TOP, S_E_BOT,
            S_D_BIRD, S_D_TOP, S_D_BOT: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic state_e next_draw(state_e s);
        case (s)
            S_E_BIRD: return S_E_TOP;
            S_E_TOP:  return S_E_BOT;
            S_E_BOT:  return S_UPDATE;
            S_D_BIRD: return S_D_TOP;
            S_D_TOP:  return S_D_BOT;
            default:  return S_WAIT;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic        go_q;
    logic        tick_pending_q, tick_pending_d;
    logic        flap_pending_q, flap_pending_d;
    logic        done_q, done_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  cur_state_q, cur_state_d;
    logic        start_draw_q, start_draw_d;
    logic        plot_q, plot_d;
    logic        erase_q, erase_d;
    logic        update_pos_q, update_pos_d;
    logic        flap_q, flap_d;
    logic        game_reset_q, game_reset_d;
    logic [7:0]  score_q, score_d;
    logic        game_over_q, game_over_d;
    logic        draw_timeout_q, draw_timeout_d;
    logic        frame_overrun_q, frame_overrun_d;

    logic go_rise, in_draw, fd_ok, to_hit, pend, entering;

    always_comb begin
        state_d         = state_q;
        tick_pending_d  = tick_pending_q;
        done_d          = done_q;
        score_d         = score_q;
        draw_timeout_d  = draw_timeout_q;
        frame_overrun_d = frame_overrun_q;
        game_reset_d    = 1'b0;

        go_rise = go & ~go_q;
        in_draw = is_draw(state_q);
        // finished_draw only counts after the start pulse and once per rectangle
        fd_ok   = in_draw & finished_draw & ~start_draw_q & ~done_q;
        to_hit  = in_draw & ~done_q & ~fd_ok &
                  (cnt_q == DRAW_TIMEOUT - 16'd1);

        if (frame_tick && state_q != S_WAIT && state_q != S_OVER) begin
            if (tick_pending_q) frame_overrun_d = 1'b1;
            else                tick_pending_d  = 1'b1;
        end

        pend = flap_pending_q |
               (go_rise & (state_q != S_IDLE) & (state_q != S_OVER));
        flap_pending_d = pend;

        if (fd_ok) done_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (go_rise) begin
                    state_d        = S_WAIT;
                    game_reset_d   = 1'b1;
                    score_d        = 8'd0;
                    tick_pending_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (frame_tick || tick_pending_q) begin
                    state_d        = S_E_BIRD;
                    tick_pending_d = 1'b0;
                end
            end
            S_UPDATE: begin
                flap_pending_d = 1'b0;
                if (wall_wrap && score_q < SCORE_MAX)
                    score_d = score_q + 8'd1;
                state_d = S_CHECK;
            end
            S_CHECK: state_d = collision ? S_OVER : S_D_BIRD;
            S_OVER: begin
                if (go_rise) state_d = S_IDLE;
            end
            default: begin
                if (done_q || to_hit) state_d = next_draw(state_q);
                if (to_hit) draw_timeout_d = 1'b1;
            end
        endcase

        entering = (state_d != state_q);
        if (entering) done_d = 1'b0;
        cnt_d = (entering || !is_draw(state_d)) ? 16'd0 : cnt_q + 16'd1;

        case (state_d)
            S_E_BIRD, S_D_BIRD: cur_state_d = 4'd0;
            S_E_TOP,  S_D_TOP:  cur_state_d = 4'd1;
            S_E_BOT,  S_D_BOT:  cur_state_d = 4'd2;
            default:            cur_state_d = 4'd3;
        endcase

        erase_d      = (state_d == S_E_BIRD) | (state_d == S_E_TOP) |
                       (state_d == S_E_BOT);
        start_draw_d = is_draw(state_d) & entering;
        plot_d       = is_draw(state_d) & (entering | (plot_q & ~fd_ok));
        update_pos_d = (state_d == S_UPDATE);
        flap_d       = (state_d == S_UPDATE) & pend;
        game_over_d  = (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            go_q            <= 1'b0;
            tick_pending_q  <= 1'b0;
            flap_pending_q  <= 1'b0;
            done_q          <= 1'b0;
            cnt_q           <= 16'd0;
            cur_state_q     <= 4'd3;
            start_draw_q    <= 1'b0;
            plot_q          <= 1'b0;
            erase_q         <= 1'b0;
            update_pos_q    <= 1'b0;
            flap_q          <= 1'b0;
            game_reset_q    <= 1'b0;
            score_q         <= 8'd0;
            game_over_q     <= 1'b0;
            draw_timeout_q  <= 1'b0;
            frame_overrun_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            go_q            <= go;
            tick_pending_q  <= tick_pending_d;
            flap_pending_q  <= flap_pending_d;
            done_q          <= done_d;
            cnt_q           <= cnt_d;
            cur_state_q     <= cur_state_d;
            start_draw_q    <= start_draw_d;
            plot_q          <= plot_d;
            erase_q         <= erase_d;
            update_pos_q    <= update_pos_d;
            flap_q          <= flap_d;
            game_reset_q    <= game_reset_d;
            score_q         <= score_d;
            game_over_q     <= game_over_d;
            draw_timeout_q  <= draw_timeout_d;
            frame_overrun_q <= frame_overrun_d;
        end
    end

    assign cur_state     = cur_state_q;
    assign start_draw    = start_draw_q;
    assign plot          = plot_q;
    assign erase         = erase_q;
    assign update_pos    = update_pos_q;
    assign flap          = flap_q;
    assign game_reset    = game_reset_q;
    assign score         = score_q;
    assign game_over     = game_over_q;
    assign draw_timeout  = draw_timeout_q;
    assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control with a simple rectangle-drawer responder.
// Checks frame sequencing, flap, score saturation, game over and watchdogs.
module tb_game_control;

    localparam int T = 20000;

    logic       clk = 1'b0;
    logic       reset, go, frame_tick, finished_draw;
    logic       collision, wall_wrap;
    logic [3:0] cur_state;
    logic       start_draw, plot, erase, update_pos, flap;
    logic       game_reset, game_over, draw_timeout, frame_overrun;
    logic [7:0] score;

    game_control dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .frame_tick    (frame_tick),
        .finished_draw (finished_draw),
        .collision     (collision),
        .wall_wrap     (wall_wrap),
        .cur_state     (cur_state),
        .start_draw    (start_draw),
        .plot          (plot),
        .erase         (erase),
        .update_pos    (update_pos),
        .flap          (flap),
        .game_reset    (game_reset),
        .score         (score),
        .game_over     (game_over),
        .draw_timeout  (draw_timeout),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int         cyc, n_sd, n_up, n_flap, flap_alone, n_gr;
    int         stab_err, fd_cnt, dtop_delay, fcyc;
    int         sd_cyc [16];
    logic [3:0] log_cs [16];
    logic       log_er [16];
    logic [3:0] prev_cs, up_cs, chk_cs;
    logic       prev_up;
    bit         press_mode, tick_mode;

    int exp_cs [6] = '{0, 1, 2, 0, 1, 2};
    int exp_er [6] = '{1, 1, 1, 0, 0, 0};

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        fcyc++;
        if (start_draw) begin
            if (n_sd < 16) begin
                sd_cyc[n_sd] = cyc;
                log_cs[n_sd] = cur_state;
                log_er[n_sd] = erase;
            end
            n_sd++;
            fd_cnt = (cur_state == 4'd1 && !erase) ? dtop_delay : 10;
        end else if (plot && cur_state != prev_cs) begin
            stab_err++;
        end
        if (update_pos) begin
            n_up++;
            up_cs = cur_state;
        end
        if (prev_up) chk_cs = cur_state;
        if (flap) begin
            n_flap++;
            if (!update_pos) flap_alone++;
        end
        if (game_reset) n_gr++;
        prev_cs = cur_state;
        prev_up = update_pos;

        finished_draw = 1'b0;
        if (!start_draw && fd_cnt > 0) begin
            fd_cnt--;
            if (fd_cnt == 0) finished_draw = 1'b1;
        end
        if (press_mode)
            go = (fcyc == 5 || fcyc == 6 || fcyc == 15 ||
                  fcyc == 16 || fcyc == 25 || fcyc == 26);
        frame_tick = tick_mode && (fcyc == 5 || fcyc == 15);
    endtask

    task automatic clear_mon();
        n_sd = 0;
        n_up = 0;
        n_flap = 0;
        flap_alone = 0;
        stab_err = 0;
        fcyc = 0;
    endtask

    task automatic run_frame(int budget);
        bit done;
        done = 1'b0;
        clear_mon();
        frame_tick = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (game_over || (n_sd == 6 && cur_state == 4'd3)) begin
                done = 1'b1;
                break;
            end
        end
        check("frame_done", {31'd0, done}, 32'd1);
    endtask

    task automatic press();
        go = 1'b1;
        step();
        go = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int g0;
        reset = 1'b1;
        go = 1'b0;
        frame_tick = 1'b0;
        finished_draw = 1'b0;
        collision = 1'b0;
        wall_wrap = 1'b0;
        dtop_delay = 10;
        fd_cnt = 0;
        cyc = 0;
        n_gr = 0;
        prev_cs = 4'd3;
        prev_up = 1'b0;
        press_mode = 1'b0;
        tick_mode = 1'b0;
        clear_mon();

        repeat (3) step();
        check("rst_cur_state", 32'(cur_state), 32'd3);
        check("rst_pulses", {26'd0, start_draw, plot, erase,
              update_pos, flap, game_reset}, 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_flags", {29'd0, game_over, draw_timeout,
              frame_overrun}, 32'd0);
        reset = 1'b0;
        step();

        go = 1'b1;
        repeat (5) step();
        go = 1'b0;
        repeat (3) step();
        check("start_game_reset", 32'(n_gr), 32'd1);
        check("start_score", 32'(score), 32'd0);
        check("start_cur_state", 32'(cur_state), 32'd3);

        run_frame(200);
        check("f1_start_draws", 32'(n_sd), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("f1_seq_cs", 32'(log_cs[i]), 32'(exp_cs[i]));
            check("f1_seq_erase", 32'(log_er[i]), 32'(exp_er[i]));
        end
        check("f1_update_pos", 32'(n_up), 32'd1);
        check("f1_no_flap", 32'(n_flap), 32'd0);
        check("f1_update_cs", 32'(up_cs), 32'd3);
        check("f1_check_cs", 32'(chk_cs), 32'd3);
        check("f1_cs_stable", 32'(stab_err), 32'd0);
        check("f1_rect_len", 32'(sd_cyc[1] - sd_cyc[0]), 32'd12);
        check("f1_timeout", 32'(draw_timeout), 32'd0);
        check("f1_overrun", 32'(frame_overrun), 32'd0);

        press_mode = 1'b1;
        run_frame(200);
        press_mode = 1'b0;
        go = 1'b0;
        check("f2_one_flap", 32'(n_flap), 32'd1);
        check("f2_flap_with_upd", 32'(flap_alone), 32'd0);
        run_frame(200);
        check("f3_no_flap", 32'(n_flap), 32'd0);
        check("f3_score", 32'(score), 32'd0);

        wall_wrap = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            run_frame(200);
            check("score_sat", 32'(score), (i > 255) ? 32'd255 : 32'(i));
        end

        collision = 1'b1;
        run_frame(200);
        check("co_game_over", 32'(game_over), 32'd1);
        check("co_no_d_bird", 32'(n_sd), 32'd3);
        check("co_update", 32'(n_up), 32'd1);
        check("co_score", 32'(score), 32'd255);
        for (int k = 0; k < 2; k++) begin
            frame_tick = 1'b1;
            repeat (6) step();
        end
        check("go_ticks_ignored", 32'(n_sd), 32'd3);
        check("go_still_over", 32'(game_over), 32'd1);
        check("go_no_overrun", 32'(frame_overrun), 32'd0);
        press();
        check("idle_game_over", 32'(game_over), 32'd0);
        check("idle_score_kept", 32'(score), 32'd255);
        check("idle_cur_state", 32'(cur_state), 32'd3);
        collision = 1'b0;
        wall_wrap = 1'b0;
        g0 = n_gr;
        press();
        check("restart_reset", 32'(n_gr), 32'(g0 + 1));
        check("restart_score", 32'(score), 32'd0);

        clear_mon();
        tick_mode = 1'b1;
        frame_tick = 1'b1;
        repeat (250) step();
        tick_mode = 1'b0;
        check("ov_frames", 32'(n_up), 32'd2);
        check("ov_start_draws", 32'(n_sd), 32'd12);
        check("ov_flag", 32'(frame_overrun), 32'd1);
        check("ov_cur_state", 32'(cur_state), 32'd3);

        dtop_delay = T - 1;
        run_frame(30000);
        check("sim_rect_len", 32'(sd_cyc[5] - sd_cyc[4]), 32'(T + 1));
        check("sim_no_timeout", 32'(draw_timeout), 32'd0);
        check("sim_draws", 32'(n_sd), 32'd6);

        dtop_delay = 0;
        run_frame(30000);
        check("to_rect_len", 32'(sd_cyc[5] - sd_cyc[4]), 32'(T));
        check("to_flag", 32'(draw_timeout), 32'd1);
        check("to_update", 32'(n_up), 32'd1);
        dtop_delay = 10;

        clear_mon();
        frame_tick = 1'b1;
        repeat (5) step();
        check("mid_plot", 32'(plot), 32'd1);
        reset = 1'b1;
        step();
        check("mid_rst_plot", 32'(plot), 32'd0);
        check("mid_rst_cs", 32'(cur_state), 32'd3);
        check("mid_rst_flags", {30'd0, draw_timeout, frame_overrun},
              32'd0);
        reset = 1'b0;
        repeat (20) step();
        check("mid_no_redraw", 32'(n_sd), 32'd1);
        check("mid_idle_cs", 32'(cur_state), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
